// File: rtl/vga_ball_pkg.sv
// Shared definitions for the ball/background frame-synchronous controller.
// Optional motion step is enabled by defining VGA_BALL_CTRL_BOUNCE_EN.
package vga_ball_pkg;

  localparam logic [2:0] ADDR_R    = 3'd0;
  localparam logic [2:0] ADDR_G    = 3'd1;
  localparam logic [2:0] ADDR_B    = 3'd2;
  localparam logic [2:0] ADDR_X    = 3'd3;
  localparam logic [2:0] ADDR_Y    = 3'd4;
  localparam logic [2:0] ADDR_CTRL = 3'd5;
  localparam logic [2:0] ADDR_VEL  = 3'd6;

  // Legacy state encodings, kept so external probes see the same values.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_MOVE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    COMMIT = ST_COMMIT,
    MOVE   = ST_MOVE
  } state_t;

  typedef enum logic [2:0] {
    F_R    = 3'd0,
    F_G    = 3'd1,
    F_B    = 3'd2,
    F_X    = 3'd3,
    F_Y    = 3'd4,
    F_CTRL = 3'd5,
    F_VEL  = 3'd6
  } field_e;

  localparam int unsigned NUM_FIELDS = 7;

  localparam logic [7:0]        RST_R  = 8'h00;
  localparam logic [7:0]        RST_G  = 8'h00;
  localparam logic [7:0]        RST_B  = 8'h80;
  localparam logic [9:0]        RST_X  = 10'd320;
  localparam logic [9:0]        RST_Y  = 10'd240;
  localparam logic signed [7:0] RST_DX = 8'sd1;
  localparam logic signed [7:0] RST_DY = 8'sd1;

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/vga_ball_ctrl_if.sv
// Avalon-MM write-only slave bus for the ball controller register file.
interface vga_ball_ctrl_if;
  logic        chipselect;
  logic        write;
  logic [2:0]  address;
  logic [15:0] writedata;

  modport master (output chipselect, output write, output address, output writedata);
  modport slave  (input  chipselect, input  write, input  address, input  writedata);
endinterface

// File: rtl/vga_ball_bounce.sv
// One-axis bounce step: advance position by signed velocity, reflect at [lo, hi].
module vga_ball_bounce (
  input  logic [9:0]        pos,
  input  logic signed [7:0] vel,
  input  logic [9:0]        lo,
  input  logic [9:0]        hi,
  output logic [9:0]        pos_next,
  output logic signed [7:0] vel_next
);
  logic signed [10:0] nx;
  logic signed [7:0]  vneg;

  always_comb begin
    nx   = $signed({1'b0, pos}) + $signed({{3{vel[7]}}, vel});
    // -128 has no positive counterpart in 8 bits; saturate instead of wrapping.
    vneg = (vel == 8'sh80) ? 8'sh7F : -vel;
    pos_next = nx[9:0];
    vel_next = vel;
    if (nx < $signed({1'b0, lo})) begin
      pos_next = lo;
      vel_next = vneg;
    end else if (nx > $signed({1'b0, hi})) begin
      pos_next = hi;
      vel_next = vneg;
    end
  end
endmodule

// File: rtl/vga_ball_ctrl.sv
// Frame-synchronous shadow/active register controller for the ball display.
// Define VGA_BALL_CTRL_BOUNCE_EN to enable per-frame bounce motion in MOVE.
module vga_ball_ctrl
  import vga_ball_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RADIUS   = 15
) (
  input  logic              clk,
  input  logic              reset,
  vga_ball_ctrl_if.slave    bus,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [7:0]        bg_r,
  output logic [7:0]        bg_g,
  output logic [7:0]        bg_b,
  output logic [9:0]        center_x,
  output logic [9:0]        center_y,
  output logic              pending,
  output logic [15:0]       frame_count
);

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);

  state_t                  state;
  logic [NUM_FIELDS-1:0]   dirty, dirty_n, wr_mask, commit_mask;
  logic                    wr, frame_start;
  logic [7:0]              sh_r, sh_g, sh_b;
  logic [9:0]              sh_x, sh_y;

  assign wr          = bus.chipselect & bus.write;
  assign frame_start = (vcount == 10'(V_ACTIVE)) && (hcount == '0);

  always_comb begin
    wr_mask = '0;
    if (wr) begin
      case (bus.address)
        ADDR_R:    wr_mask[F_R]    = 1'b1;
        ADDR_G:    wr_mask[F_G]    = 1'b1;
        ADDR_B:    wr_mask[F_B]    = 1'b1;
        ADDR_X:    wr_mask[F_X]    = 1'b1;
        ADDR_Y:    wr_mask[F_Y]    = 1'b1;
        ADDR_CTRL: wr_mask[F_CTRL] = 1'b1;
        ADDR_VEL:  wr_mask[F_VEL]  = 1'b1;
        default:   ;
      endcase
    end
  end

  // A write landing on the COMMIT cycle re-arms its dirty bit after the clear.
  always_comb begin
    commit_mask = (state == COMMIT) ? dirty : '0;
    dirty_n     = (dirty & ~commit_mask) | wr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_r <= RST_R;
      sh_g <= RST_G;
      sh_b <= RST_B;
      sh_x <= RST_X;
      sh_y <= RST_Y;
    end else begin
      if (wr_mask[F_R]) sh_r <= bus.writedata[7:0];
      if (wr_mask[F_G]) sh_g <= bus.writedata[7:0];
      if (wr_mask[F_B]) sh_b <= bus.writedata[7:0];
      if (wr_mask[F_X]) sh_x <= clamp10(bus.writedata[9:0], X_MAX);
      if (wr_mask[F_Y]) sh_y <= clamp10(bus.writedata[9:0], Y_MAX);
    end
  end

`ifdef VGA_BALL_CTRL_BOUNCE_EN
  localparam logic [9:0] X_LO = 10'(RADIUS);
  localparam logic [9:0] X_HI = 10'(H_ACTIVE - 1 - RADIUS);
  localparam logic [9:0] Y_LO = 10'(RADIUS);
  localparam logic [9:0] Y_HI = 10'(V_ACTIVE - 1 - RADIUS);

  logic                sh_ctrl, ctrl_en, x_cm, y_cm;
  logic signed [7:0]   sh_dx, sh_dy, vel_dx, vel_dy, nv_x, nv_y;
  logic [9:0]          np_x, np_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_ctrl <= 1'b0;
      sh_dx   <= RST_DX;
      sh_dy   <= RST_DY;
    end else begin
      if (wr_mask[F_CTRL]) sh_ctrl <= bus.writedata[0];
      if (wr_mask[F_VEL]) begin
        sh_dx <= bus.writedata[7:0];
        sh_dy <= bus.writedata[15:8];
      end
    end
  end

  vga_ball_bounce u_bounce_x (
    .pos(center_x), .vel(vel_dx), .lo(X_LO), .hi(X_HI), .pos_next(np_x), .vel_next(nv_x)
  );
  vga_ball_bounce u_bounce_y (
    .pos(center_y), .vel(vel_dy), .lo(Y_LO), .hi(Y_HI), .pos_next(np_y), .vel_next(nv_y)
  );
`endif
  // Without the motion step CTRL/VEL values have no consumer; only their
  // dirty bits are kept so pending reflects host writes identically.

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dirty       <= '0;
      pending     <= 1'b0;
      frame_count <= '0;
      bg_r        <= RST_R;
      bg_g        <= RST_G;
      bg_b        <= RST_B;
      center_x    <= RST_X;
      center_y    <= RST_Y;
`ifdef VGA_BALL_CTRL_BOUNCE_EN
      ctrl_en     <= 1'b0;
      vel_dx      <= RST_DX;
      vel_dy      <= RST_DY;
      x_cm        <= 1'b0;
      y_cm        <= 1'b0;
`endif
    end else begin
      dirty   <= dirty_n;
      pending <= |dirty_n;
      case (state)
        IDLE: if (frame_start) state <= COMMIT;
        COMMIT: begin
          if (dirty[F_R]) bg_r     <= sh_r;
          if (dirty[F_G]) bg_g     <= sh_g;
          if (dirty[F_B]) bg_b     <= sh_b;
          if (dirty[F_X]) center_x <= sh_x;
          if (dirty[F_Y]) center_y <= sh_y;
`ifdef VGA_BALL_CTRL_BOUNCE_EN
          if (dirty[F_CTRL]) ctrl_en <= sh_ctrl;
          if (dirty[F_VEL]) begin
            vel_dx <= sh_dx;
            vel_dy <= sh_dy;
          end
          x_cm <= dirty[F_X];
          y_cm <= dirty[F_Y];
`endif
          frame_count <= frame_count + 16'd1;
          state       <= MOVE;
        end
        MOVE: begin
`ifdef VGA_BALL_CTRL_BOUNCE_EN
          if (ctrl_en) begin
            if (!x_cm) begin
              center_x <= np_x;
              vel_dx   <= nv_x;
            end
            if (!y_cm) begin
              center_y <= np_y;
              vel_dy   <= nv_y;
            end
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_ball_ctrl.sv
// Scoreboard bench: each frame pulse queues the expected post-frame outputs.
module tb_vga_ball_ctrl;

  typedef struct {
    logic [7:0]  r, g, b;
    logic [9:0]  x, y;
    logic        pend;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [7:0]  bg_r, bg_g, bg_b;
  logic [9:0]  center_x, center_y;
  logic        pending;
  logic [15:0] frame_count;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  logic [7:0]  er = 8'h00, eg = 8'h00, eb = 8'h80;
  logic [9:0]  ex = 10'd320, ey = 10'd240;
  logic [15:0] efc = '0;

  vga_ball_ctrl_if bus ();

  vga_ball_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .RADIUS(15)) dut (
    .clk(clk), .reset(reset), .bus(bus), .hcount(hcount), .vcount(vcount),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .center_x(center_x), .center_y(center_y),
    .pending(pending), .frame_count(frame_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic push_exp(input logic pend);
    exp_t e;
    efc++;
    e.r = er; e.g = eg; e.b = eb; e.x = ex; e.y = ey; e.pend = pend; e.fc = efc;
    q.push_back(e);
  endtask

  // Drives frame_start for one cycle; returns at the start of the COMMIT cycle.
  task automatic frame_pulse();
    vcount = 10'd480;
    hcount = 11'd0;
    tick(1);
    vcount = 10'd100;
    hcount = 11'd7;
  endtask

  task automatic frame(input logic pend);
    push_exp(pend);
    frame_pulse();
    tick(4);
  endtask

  // Monitor: a frame_count step marks a commit; outputs are final after MOVE.
  initial begin
    logic [15:0] prev_fc;
    exp_t e;
    prev_fc = '0;
    forever begin
      @(negedge clk);
      if (!reset && frame_count == prev_fc + 16'd1) begin
        @(negedge clk);
        if (!reset) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit actual fc=%0d required no commit", frame_count);
          end else begin
            e = q.pop_front();
            chk("frame_count", frame_count, e.fc);
            chk("bg_r", 16'(bg_r), 16'(e.r));
            chk("bg_g", 16'(bg_g), 16'(e.g));
            chk("bg_b", 16'(bg_b), 16'(e.b));
            chk("center_x", 16'(center_x), 16'(e.x));
            chk("center_y", 16'(center_y), 16'(e.y));
            chk("pending", 16'(pending), 16'(e.pend));
          end
        end
      end
      prev_fc = frame_count;
    end
  end

  initial begin
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    vcount = 10'd100;
    hcount = 11'd7;
    tick(3);
    reset = 1'b0;
    tick(1);

    chk("rst_bg_r", 16'(bg_r), 16'h00);
    chk("rst_bg_g", 16'(bg_g), 16'h00);
    chk("rst_bg_b", 16'(bg_b), 16'h80);
    chk("rst_center_x", 16'(center_x), 16'd320);
    chk("rst_center_y", 16'(center_y), 16'd240);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_pending", 16'(pending), 16'd0);

    frame(1'b0);

    bus_write(3'd3, 16'd100);
    tick(2);
    chk("pre_commit_pending", 16'(pending), 16'd1);
    chk("pre_commit_center_x", 16'(center_x), 16'd320);
    ex = 10'd100;
    frame(1'b0);

    push_exp(1'b1);
    frame_pulse();
    bus_write(3'd0, 16'h0055);
    tick(4);
    er = 8'h55;
    frame(1'b0);

    bus_write(3'd3, 16'd900);
    bus_write(3'd4, 16'd600);
    ex = 10'd639;
    ey = 10'd479;
    frame(1'b0);

    bus_write(3'd1, 16'h0099);
    bus_write(3'd2, 16'h0034);
    bus_write(3'd1, 16'h0012);
    bus_write(3'd7, 16'hFFFF);
    eg = 8'h12;
    eb = 8'h34;
    frame(1'b0);

    bus_write(3'd5, 16'h0001);
    bus_write(3'd6, 16'h0004);
    bus_write(3'd3, 16'd622);
    bus_write(3'd4, 16'd200);
    ex = 10'd622;
    ey = 10'd200;
    frame(1'b0);
`ifdef VGA_BALL_CTRL_BOUNCE_EN
    ex = 10'd624;
`endif
    frame(1'b0);
`ifdef VGA_BALL_CTRL_BOUNCE_EN
    ex = 10'd620;
`endif
    frame(1'b0);

    // Reset lands while MOVE is active and G is dirty from the COMMIT-cycle write.
    frame_pulse();
    bus_write(3'd1, 16'h0077);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_pending", 16'(pending), 16'd0);
    chk("mid_rst_frame_count", frame_count, 16'd0);
    chk("mid_rst_bg_g", 16'(bg_g), 16'h00);
    chk("mid_rst_bg_b", 16'(bg_b), 16'h80);
    chk("mid_rst_center_x", 16'(center_x), 16'd320);
    chk("mid_rst_center_y", 16'(center_y), 16'd240);
    tick(1);
    reset = 1'b0;
    tick(2);

    er = 8'h00; eg = 8'h00; eb = 8'h80;
    ex = 10'd320; ey = 10'd240;
    efc = '0;
    frame(1'b0);

    tick(5);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
